ps2_scan_rx: RTL and testbench

PS/2 device-to-host receive front end that sits directly upstream of the keyboard text/editing logic. It synchronises and deglitches the raw `ps2_clk`/`ps2_data` lines, deframes 11-bit PS/2 frames and checks parity and stop. It folds the `E0` (extended) and `F0` (break) prefix bytes into flags. It emits one qualified key event per make/break code as a single-cycle strobe with the 8-bit scan code.

---
 rtl/ps2_pkg.sv | 19 +
 rtl/ps2_line_filter.sv | 41 ++++
 rtl/ps2_scan_rx.sv | 159 +++++++++++++++
 tb/tb_ps2_scan_rx.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared FSM state type, prefix byte codes and parity helper for the PS/2 receiver
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_e;

    localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PFX_BRK = 8'hF0;

    // PS/2 uses odd parity: data bits plus parity bit must hold an odd number of ones
    function automatic logic ps2_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: synchronises and deglitches the raw PS/2 clock, producing the filtered level and a one-cycle falling-edge strobe
module ps2_line_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line_i,
    output logic fclk_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [FILTER_LEN-1:0]  hist_q, hist_d;
    logic                   fclk_q, fclk_d, fall_q;

    // filtered level only moves once the whole history window agrees
    always_comb begin
        hist_d = {hist_q[FILTER_LEN-2:0], sync_q[SYNC_STAGES-1]};
        fclk_d = (&hist_d) ? 1'b1 : (~|hist_d) ? 1'b0 : fclk_q;
    end

    // synchroniser chain, sample history and edge strobe; idle line level is high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
            hist_q <= '1;
            fclk_q <= 1'b1;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], line_i};
            hist_q <= hist_d;
            fclk_q <= fclk_d;
            fall_q <= fclk_q & ~fclk_d;
        end
    end

    assign fclk_o = fclk_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/ps2_scan_rx.sv
// ps2_scan_rx: PS/2 device-to-host receiver that deframes scan bytes, folds E0/F0 prefixes into flags and strobes key events
module ps2_scan_rx
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [7:0] code_o,
    output logic       code_valid_o,
    output logic       is_break_o,
    output logic       is_ext_o,
    output logic       parity_err_o,
    output logic       framing_err_o
);

    localparam int                TMO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYCLES);

    logic                   fclk, fall_raw, fall, data_s;
    logic [SYNC_STAGES-1:0] dsync_q;
    ps2_state_e             state_q, state_d;
    logic [2:0]             bitcnt_q, bitcnt_d;
    logic [7:0]             shift_q, shift_d;
    logic                   par_q, par_d;
    logic [TMO_W-1:0]       tmo_q, tmo_d;
    logic                   ext_pend_q, ext_pend_d, brk_pend_q, brk_pend_d;
    logic [7:0]             code_q, code_d;
    logic                   brk_q, brk_d, ext_q, ext_d;
    logic                   valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d;

    ps2_line_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_clk_filter (
        .clk    (clk),
        .rst_n  (rst_n),
        .line_i (ps2_clk_i),
        .fclk_o (fclk),
        .fall_o (fall_raw)
    );

    // an edge only counts once the filtered clock is actually low
    assign fall   = fall_raw & ~fclk;
    assign data_s = dsync_q[SYNC_STAGES-1];

    // frame deserialiser, timeout watchdog, prefix folding and event/error strobes
    always_comb begin
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        ext_pend_d = ext_pend_q;
        brk_pend_d = brk_pend_q;
        code_d     = code_q;
        brk_d      = brk_q;
        ext_d      = ext_q;
        valid_d    = 1'b0;
        perr_d     = 1'b0;
        ferr_d     = 1'b0;
        tmo_d      = (state_q == IDLE || fall) ? '0 :
                     (tmo_q == TMO_MAX) ? tmo_q : tmo_q + TMO_W'(1);
        if (state_q != IDLE && !fall && tmo_q == TMO_MAX) begin
            state_d    = IDLE;
            ferr_d     = 1'b1;
            ext_pend_d = 1'b0;
            brk_pend_d = 1'b0;
            tmo_d      = '0;
        end else if (fall) begin
            case (state_q)
                IDLE: begin
                    if (!data_s) begin
                        state_d  = DATA;
                        bitcnt_d = '0;
                    end
                end
                DATA: begin
                    shift_d  = {data_s, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) state_d = PARITY;
                end
                PARITY: begin
                    par_d   = data_s;
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (!data_s) begin
                        ferr_d     = 1'b1;
                        ext_pend_d = 1'b0;
                        brk_pend_d = 1'b0;
                    end else if (!ps2_parity_ok(shift_q, par_q)) begin
                        perr_d     = 1'b1;
                        ext_pend_d = 1'b0;
                        brk_pend_d = 1'b0;
                    end else if (shift_q == PS2_PFX_EXT) begin
                        ext_pend_d = 1'b1;
                    end else if (shift_q == PS2_PFX_BRK) begin
                        brk_pend_d = 1'b1;
                    end else begin
                        valid_d    = 1'b1;
                        code_d     = shift_q;
                        brk_d      = brk_pend_q;
                        ext_d      = ext_pend_q;
                        ext_pend_d = 1'b0;
                        brk_pend_d = 1'b0;
                    end
                end
            endcase
        end
    end

    // state registers; reset abandons any frame in flight without raising an error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dsync_q    <= '1;
            state_q    <= IDLE;
            bitcnt_q   <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            tmo_q      <= '0;
            ext_pend_q <= 1'b0;
            brk_pend_q <= 1'b0;
            code_q     <= '0;
            brk_q      <= 1'b0;
            ext_q      <= 1'b0;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            dsync_q    <= {dsync_q[SYNC_STAGES-2:0], ps2_data_i};
            state_q    <= state_d;
            bitcnt_q   <= bitcnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            tmo_q      <= tmo_d;
            ext_pend_q <= ext_pend_d;
            brk_pend_q <= brk_pend_d;
            code_q     <= code_d;
            brk_q      <= brk_d;
            ext_q      <= ext_d;
            valid_q    <= valid_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
        end
    end

    assign code_o        = code_q;
    assign code_valid_o  = valid_q;
    assign is_break_o    = brk_q;
    assign is_ext_o      = ext_q;
    assign parity_err_o  = perr_q;
    assign framing_err_o = ferr_q;

endmodule

// File: tb/tb_ps2_scan_rx.sv
// tb_ps2_scan_rx: drives PS/2 frames (directed and random) and compares strobes/outputs against a byte-level reference model
module tb_ps2_scan_rx;

    localparam int TMO = 400;
    localparam int H   = 20;

    logic       clk = 1'b0, rst_n = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1;
    logic [7:0] code_o;
    logic       code_valid_o, is_break_o, is_ext_o, parity_err_o, framing_err_o;

    int vectors = 0, miscompares = 0;

    typedef struct {
        int         kind;
        logic [7:0] code;
        logic       brk;
        logic       ext;
    } ev_t;

    ev_t obs[$];
    ev_t exp_q[$];

    logic       m_ext = 1'b0, m_brk = 1'b0, m_ob = 1'b0, m_oe = 1'b0;
    logic [7:0] m_code = 8'h00;

    ps2_scan_rx #(
        .SYNC_STAGES    (2),
        .FILTER_LEN     (4),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ps2_clk_i     (ps2_clk),
        .ps2_data_i    (ps2_data),
        .code_o        (code_o),
        .code_valid_o  (code_valid_o),
        .is_break_o    (is_break_o),
        .is_ext_o      (is_ext_o),
        .parity_err_o  (parity_err_o),
        .framing_err_o (framing_err_o)
    );

    always #5 clk = ~clk;

    // record every strobe cycle; overlapping strobes become kind 3 and never match
    always @(negedge clk) begin
        int  n;
        ev_t e;
        n = int'(code_valid_o) + int'(parity_err_o) + int'(framing_err_o);
        if (n != 0) begin
            e.kind = (n > 1) ? 3 : code_valid_o ? 0 : parity_err_o ? 1 : 2;
            e.code = code_o;
            e.brk  = is_break_o;
            e.ext  = is_ext_o;
            obs.push_back(e);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    // byte-level model of what the receiver should report for one complete frame
    task automatic model(input logic [7:0] b, input logic p, input logic stop);
        if (!stop) begin
            exp_q.push_back('{kind: 2, code: 8'h00, brk: 1'b0, ext: 1'b0});
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else if ($countones({b, p}) % 2 == 0) begin
            exp_q.push_back('{kind: 1, code: 8'h00, brk: 1'b0, ext: 1'b0});
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            exp_q.push_back('{kind: 0, code: b, brk: m_brk, ext: m_ext});
            m_code = b;
            m_ob   = m_brk;
            m_oe   = m_ext;
            m_brk  = 1'b0;
            m_ext  = 1'b0;
        end
    endtask

    task automatic check_all(input string tag);
        ev_t o, x;
        chk({tag, ".count"}, obs.size(), exp_q.size());
        while (obs.size() > 0 && exp_q.size() > 0) begin
            o = obs.pop_front();
            x = exp_q.pop_front();
            chk({tag, ".kind"}, o.kind, x.kind);
            if (x.kind == 0) begin
                chk({tag, ".code"}, o.code, x.code);
                chk({tag, ".brk"}, o.brk, x.brk);
                chk({tag, ".ext"}, o.ext, x.ext);
            end
        end
        obs.delete();
        exp_q.delete();
        chk({tag, ".hold_code"}, code_o, m_code);
        chk({tag, ".hold_brk"}, is_break_o, m_ob);
        chk({tag, ".hold_ext"}, is_ext_o, m_oe);
    endtask

    task automatic clock_bit(input logic v);
        @(negedge clk) ps2_data = v;
        repeat (H) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (H) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send(input logic [7:0] b, input bit flip, input bit stop, input string tag);
        logic p;
        p = ~^b ^ flip;
        clock_bit(1'b0);
        for (int k = 0; k < 8; k++) clock_bit(b[k]);
        clock_bit(p);
        clock_bit(stop);
        @(negedge clk) ps2_data = 1'b1;
        model(b, p, stop);
        repeat (30) @(negedge clk);
        check_all(tag);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, ".code"}, code_o, 8'h00);
        chk({tag, ".strobes"}, {code_valid_o, parity_err_o, framing_err_o}, 3'b000);
        chk({tag, ".flags"}, {is_break_o, is_ext_o}, 2'b00);
    endtask

    initial begin
        logic [7:0] b;
        int         r;
        repeat (5) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check_all("post_reset");

        send(8'h1C, 0, 1, "make");

        send(8'hF0, 0, 1, "brk_pfx");
        send(8'h1C, 0, 1, "brk_1c");
        send(8'h1C, 0, 1, "after_brk");

        send(8'hE0, 0, 1, "ext_pfx");
        send(8'hF0, 0, 1, "ext_brk_pfx");
        send(8'h75, 0, 1, "ext_brk_75");
        send(8'hF0, 0, 1, "brk_ext_pfx");
        send(8'hE0, 0, 1, "brk_ext_pfx2");
        send(8'h75, 0, 1, "brk_ext_75");

        send(8'hF0, 0, 1, "perr_pfx");
        send(8'h1C, 1, 1, "perr");
        send(8'h1C, 0, 1, "perr_clears");
        send(8'hF0, 0, 1, "perr_new_pfx");
        send(8'h1C, 0, 1, "perr_new_brk");
        send(8'hE0, 0, 1, "ferr_pfx");
        send(8'h1C, 0, 0, "bad_stop");
        send(8'h1C, 0, 1, "ferr_clears");

        send(8'hF0, 0, 1, "tmo_pfx");
        clock_bit(1'b0);
        for (int k = 0; k < 4; k++) clock_bit(k[0]);
        @(negedge clk) ps2_data = 1'b1;
        repeat (TMO + 60) @(negedge clk);
        exp_q.push_back('{kind: 2, code: 8'h00, brk: 1'b0, ext: 1'b0});
        m_ext = 1'b0;
        m_brk = 1'b0;
        check_all("timeout");
        send(8'h1C, 0, 1, "after_tmo");

        @(negedge clk) ps2_data = 1'b0;
        repeat (5) @(negedge clk);
        ps2_clk = 1'b0;
        @(negedge clk) ps2_clk = 1'b1;
        repeat (10) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (3) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (10) @(negedge clk);
        ps2_data = 1'b1;
        repeat (30) @(negedge clk);
        check_all("glitch");
        send(8'h1C, 0, 1, "after_glitch");

        send(8'hF0, 0, 1, "rst_pfx");
        clock_bit(1'b0);
        for (int k = 0; k < 3; k++) clock_bit(1'b1);
        @(negedge clk) rst_n = 1'b0;
        #1;
        check_outputs_zero("mid_reset");
        repeat (3) @(negedge clk);
        rst_n    = 1'b1;
        ps2_data = 1'b1;
        m_ext    = 1'b0;
        m_brk    = 1'b0;
        m_code   = 8'h00;
        m_ob     = 1'b0;
        m_oe     = 1'b0;
        repeat (30) @(negedge clk);
        check_all("after_reset");
        send(8'h1C, 0, 1, "reset_1c");

        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            b = (r < 2) ? 8'hE0 : (r < 4) ? 8'hF0 : 8'($urandom);
            send(b, $urandom_range(0, 7) == 0, $urandom_range(0, 11) != 0, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
